// File: rtl/uitpg_mode_ctrl_if.sv
// Host configuration write bus for the TPG mode sequencer.
// A single-cycle strobe carries the requested state and mode.
interface uitpg_mode_ctrl_if;
    logic       I_cfg_wr;
    logic [1:0] I_cfg_state;
    logic [3:0] I_cfg_mode;

    modport master (
        output I_cfg_wr,
        output I_cfg_state,
        output I_cfg_mode
    );

    modport slave (
        input I_cfg_wr,
        input I_cfg_state,
        input I_cfg_mode
    );
endinterface

// File: rtl/uitpg_mode_ctrl.sv
// TPG pattern-select sequencer: auto-cycle, push button and host write, applied at VS rise.
// Optional UITPG_SKIP_MASK_EN: advance skips modes whose I_skip_mask bit is set.
module uitpg_mode_ctrl #(
    parameter int unsigned FRAMES_PER_MODE = 60,
    parameter int unsigned DB_W            = 20,
    parameter logic [DB_W-1:0] DEBOUNCE_CYC = 20'd500000
) (
    input  logic                     I_tpg_clk,
    input  logic                     I_tpg_rstn,
    input  logic                     I_tpg_vs,
    input  logic                     I_btn_n,
    uitpg_mode_ctrl_if.slave         cfg,
    input  logic [15:0]              I_skip_mask,
    output logic [3:0]               O_dis_mode,
    output logic                     O_mode_upd,
    output logic [1:0]               O_state,
    output logic [15:0]              O_frame_cnt
);

    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    localparam int unsigned DWELL_W =
        (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST =
        DWELL_W'(FRAMES_PER_MODE - 1);
    localparam logic [DB_W-1:0] DB_LAST = DEBOUNCE_CYC - 1'b1;

    // VS edge detect
    logic vs_r;
    logic vs_rise;

    assign vs_rise = I_tpg_vs & ~vs_r;

    always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
        if (!I_tpg_rstn) begin
            vs_r        <= 1'b0;
            O_frame_cnt <= 16'd0;
        end else begin
            vs_r <= I_tpg_vs;
            if (vs_rise) begin
                O_frame_cnt <= O_frame_cnt + 16'd1;
            end
        end
    end

    // Button: synchronize, then accept a level only after it has been stable
    logic [1:0]      btn_sync;
    logic            btn_s;
    logic            btn_flt;
    logic [DB_W-1:0] db_cnt;
    logic            db_done;
    logic            btn_press;
    logic            btn_pend;

    assign btn_s     = btn_sync[1];
    assign db_done   = (btn_s != btn_flt) && (db_cnt == DB_LAST);
    assign btn_press = db_done && !btn_s;

    always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
        if (!I_tpg_rstn) begin
            btn_sync <= 2'b11;
            btn_flt  <= 1'b1;
            db_cnt   <= '0;
        end else begin
            btn_sync <= {btn_sync[0], I_btn_n};
            if (btn_s == btn_flt) begin
                db_cnt <= '0;
            end else if (db_done) begin
                btn_flt <= btn_s;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A press landing on the vs_rise edge belongs to the next frame
    always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
        if (!I_tpg_rstn) begin
            btn_pend <= 1'b0;
        end else if (btn_press) begin
            btn_pend <= 1'b1;
        end else if (vs_rise) begin
            btn_pend <= 1'b0;
        end
    end

    // Host write capture; last write before vs_rise wins
    logic       cfg_ok;
    logic       cfg_pend;
    state_e     cfg_state_q;
    logic [3:0] cfg_mode_q;

    assign cfg_ok = cfg.I_cfg_wr && (cfg.I_cfg_state != 2'd3);

    always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
        if (!I_tpg_rstn) begin
            cfg_pend    <= 1'b0;
            cfg_state_q <= ST_AUTO;
            cfg_mode_q  <= 4'd0;
        end else if (cfg_ok) begin
            cfg_pend    <= 1'b1;
            cfg_state_q <= state_e'(cfg.I_cfg_state);
            cfg_mode_q  <= cfg.I_cfg_mode;
        end else if (vs_rise) begin
            cfg_pend <= 1'b0;
        end
    end

    // Next mode on advance
    logic [3:0] mode_q;
    logic [3:0] adv_mode;

`ifdef UITPG_SKIP_MASK_EN
    logic [3:0] cand;
    logic       adv_found;

    always_comb begin
        adv_mode  = mode_q;
        adv_found = 1'b0;
        cand      = mode_q;
        for (int i = 1; i < 16; i++) begin
            cand = mode_q + 4'(i);
            if (!adv_found && !I_skip_mask[cand]) begin
                adv_mode  = cand;
                adv_found = 1'b1;
            end
        end
    end
`else
    logic unused_skip_mask;

    assign unused_skip_mask = ^I_skip_mask;
    assign adv_mode         = mode_q + 4'd1;
`endif

    // Sequencer FSM
    state_e             state_q;
    state_e             state_nxt;
    logic [3:0]         mode_nxt;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_nxt;
    logic               upd_q;
    logic               upd_nxt;

    always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
        if (!I_tpg_rstn) begin
            state_q <= ST_AUTO;
            mode_q  <= 4'd0;
            dwell_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            dwell_q <= dwell_nxt;
            upd_q   <= upd_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        dwell_nxt = dwell_q;
        upd_nxt   = 1'b0;
        if (vs_rise) begin
            if (cfg_pend) begin
                state_nxt = cfg_state_q;
                mode_nxt  = cfg_mode_q;
                dwell_nxt = '0;
            end else if (btn_pend) begin
                unique case (state_q)
                    ST_AUTO: begin
                        mode_nxt  = adv_mode;
                        dwell_nxt = '0;
                    end
                    ST_MANUAL: mode_nxt = adv_mode;
                    default:   mode_nxt = mode_q;
                endcase
            end else if (state_q == ST_AUTO) begin
                if (dwell_q == DWELL_LAST) begin
                    mode_nxt  = adv_mode;
                    dwell_nxt = '0;
                end else begin
                    dwell_nxt = dwell_q + 1'b1;
                end
            end
            upd_nxt = (mode_nxt != mode_q);
        end
    end

    assign O_dis_mode = mode_q;
    assign O_mode_upd = upd_q;
    assign O_state    = state_q;

endmodule
